color_matrix_pipe: RTL and testbench
====================================

COLOR_MATRIX_PIPE -- requirements
Module: color_matrix_pipe

Interface
REQ-001 SHALL have parameter CH_W, default 8, bits per colour channel.
REQ-002 SHALL have parameter COEF_W, default 18, signed coefficient width.
REQ-003 SHALL have parameter FRAC_BITS, default 14, coefficient fraction bits (Q(COEF_W-FRAC_BITS).FRAC_BITS).
REQ-004 SHALL have port clk  in  1  clock; reset rst_n, asynchronous, active-low; clock clk.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports s_valid in 1, s_ready out 1, s_data in 3*CH_W {R,G,B}, s_sof in 1 (first pixel of frame).
REQ-007 SHALL have ports m_valid out 1, m_ready in 1, m_data out 3*CH_W, m_sof out 1.
REQ-008 SHALL have ports coef_wr_en in 1, coef_wr_addr in 4, coef_wr_data in COEF_W, coef_commit in 1 (shadow bank write and commit request).
REQ-009 SHALL have ports commit_pending out 1, sat_flag out 1 (sticky clamp event), sat_clr in 1, busy out 1 (any stage valid).

Function
REQ-010 SHALL implement a 4-stage pipeline: S1 capture, S2 nine signed products, S3 row sums plus rounding plus offset, S4 clamp into output register; latency 4 cycles from accepted beat to m_valid when m_ready stays high.
REQ-011 SHALL stall all stages together while m_valid=1 and m_ready=0; s_ready = m_ready | ~m_valid; no beat lost, duplicated or reordered.
REQ-012 SHALL accept a beat only when s_valid & s_ready; m_sof SHALL travel with its pixel.
REQ-013 SHALL compute per row i: out_i = clamp(((sum_j C[i][j]*P_j) + 2^(FRAC_BITS-1)) >>> FRAC_BITS + OFF_i), pixels zero-extended unsigned, products CH_W+COEF_W+1 bits, sums two guard bits wider, no intermediate truncation.
REQ-014 SHALL clamp to [0, 2^CH_W-1]; any clamp sets sat_flag the cycle the clamped pixel leaves S4.
REQ-015 SHALL clear sat_flag on sat_clr; a simultaneous new clamp event SHALL win (flag stays 1).
REQ-016 SHALL map coef_wr_addr 0-8 to C row-major, 9-11 to OFF_R/G/B (signed integer, output LSB units, low CH_W+1 bits of coef_wr_data used), 12-15 ignored; writes go to the shadow bank only.
REQ-017 SHALL set commit_pending on coef_commit; while pending, the active bank SHALL load from shadow on the first accepted beat with s_sof=1 (that pixel uses the new bank), or immediately when busy=0 and s_valid=0.
REQ-018 SHALL latch a coefficient write and coef_commit in the same cycle with the write included in the commit.
REQ-019 SHALL, on coef_commit in the same cycle as an accepted s_sof beat, apply the new bank from the next s_sof, not the current one.
REQ-020 SHALL keep the active bank constant for all pixels between two commits; in-flight pixels SHALL finish with the bank they entered with.

Reset
REQ-021 SHALL, on rst_n low, clear all stage valids, m_valid, m_sof, m_data, commit_pending, sat_flag, busy, and drive s_ready=1 after reset.
REQ-022 SHALL reset both banks to identity (diagonal 2^FRAC_BITS, others 0, offsets 0); reset mid-frame SHALL discard in-flight pixels.

Configuration
REQ-023 SHALL, with CCM_BYPASS_EN defined, add port cfg_bypass in 1; when 1, m_data equals the accepted s_data with the same 4-cycle latency, sat_flag unaffected, sampled per beat at S1.
REQ-024 SHALL, without CCM_BYPASS_EN, omit cfg_bypass and always apply the matrix.

Structure
REQ-025 SHALL place coefficient address map constants, identity bank constant and default CH_W/COEF_W/FRAC_BITS in shared package ccm_pkg.
REQ-026 SHALL use sub-module ccm_dot3 (one row: three products, sum, round, offset, clamp, sat output), instantiated three times.

Verification
REQ-027 SHALL cover: reset banks, input 0x804020 -> output 0x804020, m_valid exactly 4 cycles after acceptance.
REQ-028 SHALL cover: C = 2.0 diagonal committed, input 0xC0C0C0 -> 0xFFFFFF, sat_flag=1; sat_clr -> 0.
REQ-029 SHALL cover: row R = {0,-1.0,0}, input 0x10FF10 -> R=0x00, sat_flag=1; OFF_G=+5 on 0x000000 -> G=0x05.
REQ-030 SHALL cover: 64-pixel ramp stream with m_ready low for 10 random windows -> all 64 out, in order, values unchanged versus golden model.
REQ-031 SHALL cover: commit mid-frame -> commit_pending=1 until next s_sof beat; that pixel and later use new bank, earlier ones old bank.
REQ-032 SHALL cover: rst_n asserted with 3 pixels in flight -> m_valid=0 immediately, no stale output after release, banks identity.

Source files
------------

// File: rtl/ccm_pkg.sv
// Shared constants for the colour correction matrix pipeline: default widths,
// coefficient address map and the identity bank pattern.
package ccm_pkg;

  localparam int unsigned CCM_CH_W      = 8;
  localparam int unsigned CCM_COEF_W    = 18;
  localparam int unsigned CCM_FRAC_BITS = 14;

  localparam logic [3:0] CCM_ADDR_C_LAST = 4'd8;
  localparam logic [3:0] CCM_ADDR_OFF_R  = 4'd9;
  localparam logic [3:0] CCM_ADDR_OFF_G  = 4'd10;
  localparam logic [3:0] CCM_ADDR_OFF_B  = 4'd11;

  // Bit k set where row-major coefficient k sits on the diagonal.
  localparam logic [8:0] CCM_IDENT_DIAG = 9'b100_010_001;

endpackage

// File: rtl/ccm_dot3.sv
// One output row of the colour matrix: three signed products (S2), row sum with
// rounding and offset (S3), and a combinational clamp feeding the S4 register.
module ccm_dot3
  import ccm_pkg::*;
#(
  parameter int unsigned CH_W      = CCM_CH_W,
  parameter int unsigned COEF_W    = CCM_COEF_W,
  parameter int unsigned FRAC_BITS = CCM_FRAC_BITS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en_i,
  input  logic [CH_W-1:0]          p0_i,
  input  logic [CH_W-1:0]          p1_i,
  input  logic [CH_W-1:0]          p2_i,
  input  logic signed [COEF_W-1:0] c0_i,
  input  logic signed [COEF_W-1:0] c1_i,
  input  logic signed [COEF_W-1:0] c2_i,
  input  logic signed [CH_W:0]     off_i,
  output logic [CH_W-1:0]          res_o,
  output logic                     sat_o
);

  localparam int unsigned PW = CH_W + COEF_W + 1;
  localparam int unsigned SW = PW + 2;
  localparam logic signed [SW-1:0] Rnd = SW'(1) << (FRAC_BITS - 1);

  logic signed [PW-1:0] prod_d [3];
  logic signed [PW-1:0] prod_q [3];
  logic signed [CH_W:0] off_q;
  logic signed [SW-1:0] sum_w, acc_d, acc_q;

  always_comb begin
    // Pixels are unsigned, so they gain a zero sign bit before the signed multiply.
    prod_d[0] = PW'($signed({1'b0, p0_i})) * PW'(c0_i);
    prod_d[1] = PW'($signed({1'b0, p1_i})) * PW'(c1_i);
    prod_d[2] = PW'($signed({1'b0, p2_i})) * PW'(c2_i);
    sum_w     = SW'(prod_q[0]) + SW'(prod_q[1]) + SW'(prod_q[2]);
    acc_d     = ((sum_w + Rnd) >>> FRAC_BITS) + SW'(off_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '{default: '0};
      off_q  <= '0;
      acc_q  <= '0;
    end else if (en_i) begin
      prod_q <= prod_d;
      off_q  <= off_i;
      acc_q  <= acc_d;
    end
  end

  always_comb begin
    res_o = acc_q[CH_W-1:0];
    sat_o = 1'b0;
    if (acc_q[SW-1]) begin
      res_o = '0;
      sat_o = 1'b1;
    end else if (|acc_q[SW-2:CH_W]) begin
      res_o = '1;
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/color_matrix_pipe.sv
// 4-stage 3x3 colour correction matrix with shadow/active coefficient banks.
// Define CCM_BYPASS_EN to add the per-beat cfg_bypass input.
module color_matrix_pipe
  import ccm_pkg::*;
#(
  parameter int unsigned CH_W      = CCM_CH_W,
  parameter int unsigned COEF_W    = CCM_COEF_W,
  parameter int unsigned FRAC_BITS = CCM_FRAC_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [3*CH_W-1:0]   s_data,
  input  logic                s_sof,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [3*CH_W-1:0]   m_data,
  output logic                m_sof,
  input  logic                coef_wr_en,
  input  logic [3:0]          coef_wr_addr,
  input  logic [COEF_W-1:0]   coef_wr_data,
  input  logic                coef_commit,
  output logic                commit_pending,
  output logic                sat_flag,
  input  logic                sat_clr,
  output logic                busy
`ifdef CCM_BYPASS_EN
  ,
  input  logic                cfg_bypass
`endif
);

  localparam int unsigned DW = 3 * CH_W;
  localparam logic signed [COEF_W-1:0] OneQ = COEF_W'(1) << FRAC_BITS;

  logic signed [COEF_W-1:0] sh_coef_q  [9];
  logic signed [COEF_W-1:0] act_coef_q [9];
  logic signed [CH_W:0]     sh_off_q   [3];
  logic signed [CH_W:0]     act_off_q  [3];

  logic          s1_valid_q, s2_valid_q, s3_valid_q, m_valid_q;
  logic          s1_sof_q, s2_sof_q, s3_sof_q, m_sof_q;
  logic [DW-1:0] s1_pix_q, m_data_q;
  logic          pend_q, pend_d, sat_q, sat_d;
  logic          adv, accept, bank_load, sat_set;
  logic [CH_W-1:0] row_res [3];
  logic [2:0]      row_sat;
  logic [DW-1:0]   row_data, s4_data;
  logic            s4_sat;

  // Whole pipeline moves only when the output register can drain.
  assign adv     = ~(m_valid_q & ~m_ready);
  assign s_ready = adv;
  assign accept  = s_valid & adv;
  assign busy    = s1_valid_q | s2_valid_q | s3_valid_q | m_valid_q;

  assign bank_load = pend_q & ((accept & s_sof) | (~busy & ~s_valid));

  always_comb begin
    pend_d = pend_q;
    if (coef_commit) begin
      pend_d = 1'b1;
    end else if (bank_load) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 9; k++) begin
        sh_coef_q[k]  <= CCM_IDENT_DIAG[k] ? OneQ : '0;
        act_coef_q[k] <= CCM_IDENT_DIAG[k] ? OneQ : '0;
      end
      sh_off_q  <= '{default: '0};
      act_off_q <= '{default: '0};
      pend_q    <= 1'b0;
    end else begin
      pend_q <= pend_d;
      // A load copies the shadow as it was before this cycle's write.
      if (bank_load) begin
        act_coef_q <= sh_coef_q;
        act_off_q  <= sh_off_q;
      end
      if (coef_wr_en) begin
        if (coef_wr_addr <= CCM_ADDR_C_LAST) begin
          sh_coef_q[coef_wr_addr] <= coef_wr_data;
        end else if (coef_wr_addr <= CCM_ADDR_OFF_B) begin
          sh_off_q[2'(coef_wr_addr - CCM_ADDR_OFF_R)] <= coef_wr_data[CH_W:0];
        end
      end
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_row
    ccm_dot3 #(
      .CH_W      (CH_W),
      .COEF_W    (COEF_W),
      .FRAC_BITS (FRAC_BITS)
    ) u_dot3 (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (adv),
      .p0_i  (s1_pix_q[DW-1 -: CH_W]),
      .p1_i  (s1_pix_q[2*CH_W-1 -: CH_W]),
      .p2_i  (s1_pix_q[CH_W-1:0]),
      .c0_i  (act_coef_q[3*i]),
      .c1_i  (act_coef_q[3*i+1]),
      .c2_i  (act_coef_q[3*i+2]),
      .off_i (act_off_q[i]),
      .res_o (row_res[i]),
      .sat_o (row_sat[i])
    );
  end

  assign row_data = {row_res[0], row_res[1], row_res[2]};

`ifdef CCM_BYPASS_EN
  logic          s1_byp_q, s2_byp_q, s3_byp_q;
  logic [DW-1:0] s2_pix_q, s3_pix_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_byp_q <= 1'b0;
      s2_byp_q <= 1'b0;
      s3_byp_q <= 1'b0;
      s2_pix_q <= '0;
      s3_pix_q <= '0;
    end else if (adv) begin
      s1_byp_q <= cfg_bypass;
      s2_byp_q <= s1_byp_q;
      s3_byp_q <= s2_byp_q;
      s2_pix_q <= s1_pix_q;
      s3_pix_q <= s2_pix_q;
    end
  end

  assign s4_data = s3_byp_q ? s3_pix_q : row_data;
  assign s4_sat  = ~s3_byp_q & (|row_sat);
`else
  assign s4_data = row_data;
  assign s4_sat  = |row_sat;
`endif

  assign sat_set = adv & s3_valid_q & s4_sat;
  assign sat_d   = sat_set | (sat_q & ~sat_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      m_valid_q  <= 1'b0;
      s1_sof_q   <= 1'b0;
      s2_sof_q   <= 1'b0;
      s3_sof_q   <= 1'b0;
      m_sof_q    <= 1'b0;
      s1_pix_q   <= '0;
      m_data_q   <= '0;
      sat_q      <= 1'b0;
    end else begin
      sat_q <= sat_d;
      if (adv) begin
        s1_valid_q <= accept;
        s1_sof_q   <= s_sof;
        s1_pix_q   <= s_data;
        s2_valid_q <= s1_valid_q;
        s2_sof_q   <= s1_sof_q;
        s3_valid_q <= s2_valid_q;
        s3_sof_q   <= s2_sof_q;
        m_valid_q  <= s3_valid_q;
        m_sof_q    <= s3_sof_q;
        if (s3_valid_q) begin
          m_data_q <= s4_data;
        end
      end
    end
  end

  assign m_valid        = m_valid_q;
  assign m_sof          = m_sof_q;
  assign m_data         = m_data_q;
  assign commit_pending = pend_q;
  assign sat_flag       = sat_q;

endmodule

// File: tb/tb_color_matrix_pipe.sv
// Scoreboard bench for color_matrix_pipe: randomized and directed pixels are
// scored against an arithmetic colour-matrix model with its own bank bookkeeping.
module tb_color_matrix_pipe;

  localparam int FRAC = 14;

  logic        clk, rst_n;
  logic        s_valid, s_ready, s_sof;
  logic [23:0] s_data;
  logic        m_valid, m_ready, m_sof;
  logic [23:0] m_data;
  logic        coef_wr_en, coef_commit, commit_pending, sat_flag, sat_clr, busy;
  logic [3:0]  coef_wr_addr;
  logic [17:0] coef_wr_data;

  color_matrix_pipe dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .s_sof          (s_sof),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .m_sof          (m_sof),
    .coef_wr_en     (coef_wr_en),
    .coef_wr_addr   (coef_wr_addr),
    .coef_wr_data   (coef_wr_data),
    .coef_commit    (coef_commit),
    .commit_pending (commit_pending),
    .sat_flag       (sat_flag),
    .sat_clr        (sat_clr),
    .busy           (busy)
`ifdef CCM_BYPASS_EN
    ,
    .cfg_bypass     (1'b0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] d;
    logic        sof;
    logic        sat;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_bad   = 0;

  // Model banks: coefficients in Q4.14 as ints, offsets as ints.
  int   sh_c[9], act_c[9], sh_off[3], act_off[3];
  bit   pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 9; k++) sh_c[k] = (k % 4 == 0) ? (1 << FRAC) : 0;
    for (int k = 0; k < 3; k++) sh_off[k] = 0;
    act_c = sh_c;
    act_off = sh_off;
    pend = 1'b0;
  endtask

  function automatic exp_t model_pix(input logic [23:0] pix, input logic sof);
    exp_t   r;
    int     p[3];
    longint acc, v;
    p[0] = int'(pix[23:16]);
    p[1] = int'(pix[15:8]);
    p[2] = int'(pix[7:0]);
    r.sof = sof;
    r.sat = 1'b0;
    r.d   = '0;
    for (int i = 0; i < 3; i++) begin
      acc = 0;
      for (int j = 0; j < 3; j++) acc += longint'(act_c[3*i+j]) * longint'(p[j]);
      v = ((acc + (longint'(1) <<< (FRAC - 1))) >>> FRAC) + longint'(act_off[i]);
      if (v < 0) begin
        v = 0;
        r.sat = 1'b1;
      end else if (v > 255) begin
        v = 255;
        r.sat = 1'b1;
      end
      r.d[(2-i)*8 +: 8] = v[7:0];
    end
    return r;
  endfunction

  // Monitor: every output handshake pops one expected pixel.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {8'h0, m_data}, 32'hDEAD);
      end else begin
        e = sb.pop_front();
        chk("m_data", {8'h0, m_data}, {8'h0, e.d});
        chk("m_sof", {31'h0, m_sof}, {31'h0, e.sof});
        if (e.sat) chk("sat_flag_on_clamp", {31'h0, sat_flag}, 32'h1);
      end
    end
  end

  task automatic send(input logic [23:0] d, input logic sof, input logic cmt);
    bit acc;
    int w;
    w = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    forever begin
      #4;
      acc = s_ready;
      coef_commit = acc & cmt;
      @(posedge clk);
      if (acc) break;
      w++;
      if (w > 200) begin
        chk("s_ready_timeout", 32'h0, 32'h1);
        break;
      end
      @(negedge clk);
    end
    if (acc) begin
      if (pend && sof) begin
        act_c = sh_c;
        act_off = sh_off;
        pend = 1'b0;
      end
      if (cmt) pend = 1'b1;
      sb.push_back(model_pix(d, sof));
    end
    #1;
    coef_commit = 1'b0;
    chk("commit_pending", {31'h0, commit_pending}, {31'h0, pend});
  endtask

  task automatic drain();
    int w;
    @(negedge clk);
    s_valid = 1'b0;
    s_sof   = 1'b0;
    for (w = 0; w < 300; w++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0 && !busy) break;
    end
    if (w >= 300) chk("drain_timeout", sb.size(), 32'h0);
  endtask

  task automatic wr(input logic [3:0] addr, input int val);
    logic [17:0] d;
    d = val[17:0];
    @(negedge clk);
    coef_wr_en   = 1'b1;
    coef_wr_addr = addr;
    coef_wr_data = d;
    @(posedge clk);
    #1;
    coef_wr_en = 1'b0;
    if (addr <= 4'd8) sh_c[addr] = int'($signed(d));
    else if (addr <= 4'd11) sh_off[addr - 4'd9] = int'($signed(d[8:0]));
  endtask

  // Only called with the pipeline drained and s_valid low, so the bank loads at once.
  task automatic commit_idle();
    @(negedge clk);
    coef_commit = 1'b1;
    @(posedge clk);
    #1;
    coef_commit = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_commit_done", {31'h0, commit_pending}, 32'h0);
    act_c = sh_c;
    act_off = sh_off;
    pend = 1'b0;
  endtask

  initial begin
    int  k;
    bit  seen;
    rst_n = 1'b0;
    s_valid = 1'b0; s_data = '0; s_sof = 1'b0; m_ready = 1'b1;
    coef_wr_en = 1'b0; coef_wr_addr = '0; coef_wr_data = '0;
    coef_commit = 1'b0; sat_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_m_valid", {31'h0, m_valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_s_ready", {31'h0, s_ready}, 32'h1);
    chk("rst_pending", {31'h0, commit_pending}, 32'h0);
    chk("rst_sat", {31'h0, sat_flag}, 32'h0);
    chk("rst_m_data", {8'h0, m_data}, 32'h0);

    // Identity bank and 4-cycle latency.
    send(24'h804020, 1'b1, 1'b0);
    s_valid = 1'b0;
    for (k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (m_valid) break;
    end
    chk("latency_cycles", k, 32'd4);
    drain();
    chk("identity_data", {8'h0, m_data}, 32'h804020);

    // 2.0 on the diagonal saturates every channel.
    wr(4'd0, 32768); wr(4'd4, 32768); wr(4'd8, 32768);
    commit_idle();
    send(24'hC0C0C0, 1'b1, 1'b0);
    drain();
    chk("diag2_data", {8'h0, m_data}, 32'hFFFFFF);
    chk("diag2_sat", {31'h0, sat_flag}, 32'h1);
    @(negedge clk); sat_clr = 1'b1;
    @(posedge clk); #1 sat_clr = 1'b0;
    chk("sat_clr", {31'h0, sat_flag}, 32'h0);

    // Negative row clamps to zero; G offset adds in output LSBs.
    wr(4'd0, 0); wr(4'd1, -16384); wr(4'd2, 0); wr(4'd4, 16384); wr(4'd8, 16384);
    wr(4'd13, 12345);
    commit_idle();
    send(24'h10FF10, 1'b1, 1'b0);
    drain();
    chk("neg_row_data", {8'h0, m_data}, 32'h00FF10);
    chk("neg_row_sat", {31'h0, sat_flag}, 32'h1);
    wr(4'd10, 5);
    commit_idle();
    send(24'h000000, 1'b1, 1'b0);
    drain();
    chk("off_g_data", {8'h0, m_data}, 32'h000500);

    // Random bank, 64-pixel ramp with back-pressure windows.
    for (int a = 0; a < 9; a++) wr(4'(a), int'($urandom_range(0, 65535)) - 32768);
    for (int a = 9; a < 12; a++) wr(4'(a), int'($urandom_range(0, 40)) - 20);
    commit_idle();
    fork
      for (int n = 0; n < 64; n++)
        send({8'(n * 4), 8'(255 - n * 4), 8'(n * 2 + 10)}, n == 0, 1'b0);
      begin
        repeat (10) begin
          repeat ($urandom_range(1, 5)) @(posedge clk);
          #1 m_ready = 1'b0;
          repeat ($urandom_range(1, 4)) @(posedge clk);
          #1 m_ready = 1'b1;
        end
      end
    join
    drain();

    // Mid-frame commit switches banks at the next start of frame only.
    for (int a = 0; a < 9; a++) wr(4'(a), int'($urandom_range(0, 65535)) - 32768);
    for (int a = 9; a < 12; a++) wr(4'(a), int'($urandom_range(0, 40)) - 20);
    for (int n = 0; n < 10; n++) send(24'($urandom), n == 0, n == 4);
    for (int n = 0; n < 10; n++) send(24'($urandom), n == 0, 1'b0);
    drain();
    // Commit on a start-of-frame beat takes effect one frame later.
    for (int a = 0; a < 9; a++) wr(4'(a), int'($urandom_range(0, 65535)) - 32768);
    for (int n = 0; n < 6; n++) send(24'($urandom), n == 0, n == 0);
    for (int n = 0; n < 6; n++) send(24'($urandom), n == 0, 1'b0);
    drain();

    // Reset with pixels in flight.
    for (int n = 0; n < 5; n++) send(24'($urandom), n == 0, 1'b0);
    chk("pre_reset_m_valid", {31'h0, m_valid}, 32'h1);
    rst_n = 1'b0;
    s_valid = 1'b0;
    s_sof = 1'b0;
    #1;
    chk("reset_m_valid", {31'h0, m_valid}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    sb.delete();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (m_valid) seen = 1'b1;
    end
    chk("no_stale_output", {31'h0, seen}, 32'h0);
    chk("post_reset_s_ready", {31'h0, s_ready}, 32'h1);
    send(24'h804020, 1'b1, 1'b0);
    drain();
    chk("post_reset_identity", {8'h0, m_data}, 32'h804020);

    chk("scoreboard_empty", sb.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
